hex8_scan: RTL and testbench

Time-multiplexed scan driver for the 8-digit seven-segment display, directly upstream of the hex8 digit decoder.
- Takes a 32-bit word (8 hex nibbles).
- Selects one digit per scan slot and drives the decoder's key[3:0] nibble and the display's sel[7:0] digit-select lines.
- Latches data at frame boundaries so one frame never mixes two words.
- Optional leading-zero blanking.

---
 rtl/hex8_scan_pkg.sv | 17 +
 rtl/hex8_scan_if.sv | 23 ++
 rtl/hex8_scan_tick_gen.sv | 38 +++
 rtl/hex8_scan.sv | 89 ++++++++
 tb/tb_hex8_scan.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hex8_scan_pkg.sv
// Shared types and helpers for the 8-digit hex display scan blocks.
package hex8_pkg;

    localparam int NUM_DIGITS  = 8;
    localparam int NIBBLE_W    = 4;
    localparam int DIGIT_IDX_W = 3;

    typedef logic [DIGIT_IDX_W-1:0]         digit_idx_t;
    typedef logic [NUM_DIGITS-1:0]          digit_sel_t;
    typedef logic [NIBBLE_W-1:0]            nibble_t;
    typedef logic [NUM_DIGITS*NIBBLE_W-1:0] hex_word_t;

    function automatic digit_sel_t onehot_sel(input digit_idx_t idx);
        return digit_sel_t'(1) << idx;
    endfunction

endpackage

// File: rtl/hex8_scan_if.sv
// Data/control bundle between a display word source and the hex8 scan driver.
interface hex8_scan_if;
    import hex8_pkg::*;

    logic       en;
    hex_word_t  data_in;
    logic       blank_lz;
    nibble_t    key;
    digit_sel_t sel;
    logic       blank;
    logic       frame_done;

    modport master (
        output en, data_in, blank_lz,
        input  key, sel, blank, frame_done
    );

    modport slave (
        input  en, data_in, blank_lz,
        output key, sel, blank, frame_done
    );

endinterface

// File: rtl/hex8_scan_tick_gen.sv
// Scan-rate prescaler: one-cycle tick every DIV enabled cycles, restarts when en drops.
module scan_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("scan_tick_gen: DIV must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    // Down-counter with terminal count at zero; reload value keeps the
    // tick on the DIV-th enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= CNT_LOAD;
        end else if (!en) begin
            cnt <= CNT_LOAD;
        end else if (cnt == '0) begin
            cnt <= CNT_LOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/hex8_scan.sv
// Time-multiplexed 8-digit hex scan driver feeding the hex8 digit decoder,
// with frame-coherent word latching and optional leading-zero blanking.
module hex8_scan
    import hex8_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_FREQ = 1000
) (
    input  logic         clk,
    input  logic         reset,
    hex8_scan_if.slave   bus
);

    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    logic       tick;
    logic       wrap;
    digit_idx_t idx;
    hex_word_t  shadow;
    nibble_t    key_q;
    digit_sel_t sel_q;
    logic       blank_q;
    logic       frame_done_q;
    logic       upper_zero;
    logic       lz;

    scan_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .tick  (tick)
    );

    assign wrap = tick && (idx == LAST_IDX);

    // Current digit and everything above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx)) && (shadow[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign lz = bus.blank_lz && (idx != '0) && upper_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            shadow       <= '0;
            key_q        <= '0;
            sel_q        <= '0;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (!bus.en) begin
            // Track the live word so the first frame after enable is current.
            idx          <= '0;
            shadow       <= bus.data_in;
            key_q        <= '0;
            sel_q        <= '0;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            key_q        <= shadow[int'(idx)*NIBBLE_W +: NIBBLE_W];
            frame_done_q <= wrap;
            if (lz) begin
                sel_q   <= '0;
                blank_q <= 1'b1;
            end else begin
                sel_q   <= onehot_sel(idx);
                blank_q <= 1'b0;
            end
            if (tick) begin
                idx <= idx + digit_idx_t'(1);
            end
            if (wrap) begin
                shadow <= bus.data_in;
            end
        end
    end

    assign bus.key        = key_q;
    assign bus.sel        = sel_q;
    assign bus.blank      = blank_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hex8_scan.sv
// Bench for hex8_scan: frame-position reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hex8_scan;

    localparam int CLK_FREQ  = 8;
    localparam int SCAN_FREQ = 2;
    localparam int DIV       = CLK_FREQ / SCAN_FREQ;
    localparam int FRAME     = 8 * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    hex8_scan_if bus ();

    hex8_scan #(.CLK_FREQ(CLK_FREQ), .SCAN_FREQ(SCAN_FREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position in frame = enabled edges since enable/reset.
    int          m_pos    = 0;
    logic [31:0] m_word   = '0;
    logic [3:0]  exp_key  = '0;
    logic [7:0]  exp_sel  = '0;
    logic        exp_blank = 1'b0;
    logic        exp_fd   = 1'b0;

    function automatic int digit_at(input int pos);
        return (pos / DIV) % 8;
    endfunction

    function automatic bit leading_zero(input logic [31:0] w, input int d, input logic bl);
        return bl && (d != 0) && ((w >> (4 * d)) == 32'd0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos <= 0; m_word <= '0;
            exp_key <= '0; exp_sel <= '0; exp_blank <= 1'b0; exp_fd <= 1'b0;
        end else if (!bus.en) begin
            m_pos <= 0; m_word <= bus.data_in;
            exp_key <= '0; exp_sel <= '0; exp_blank <= 1'b0; exp_fd <= 1'b0;
        end else begin
            exp_key <= m_word[4*digit_at(m_pos) +: 4];
            if (leading_zero(m_word, digit_at(m_pos), bus.blank_lz)) begin
                exp_sel   <= 8'h00;
                exp_blank <= 1'b1;
            end else begin
                exp_sel   <= 8'h01 << digit_at(m_pos);
                exp_blank <= 1'b0;
            end
            exp_fd <= (m_pos == FRAME - 1);
            if (m_pos == FRAME - 1) m_word <= bus.data_in;
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("key", 32'(bus.key), 32'(exp_key));
        check("sel", 32'(bus.sel), 32'(exp_sel));
        check("blank", 32'(bus.blank), 32'(exp_blank));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] sel, input logic [3:0] key,
                       input logic blank, input logic fd);
        check({name, ".sel"}, 32'(bus.sel), 32'(sel));
        check({name, ".key"}, 32'(bus.key), 32'(key));
        check({name, ".blank"}, 32'(bus.blank), 32'(blank));
        check({name, ".fd"}, 32'(bus.frame_done), 32'(fd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bus.en = 1'b0; bus.data_in = '0; bus.blank_lz = 1'b0;
        #1 reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        // Reset: outputs clear immediately, restart at digit 0 with zero word.
        bus.data_in = 32'hFFFFFFFF;
        tick();
        bus.en = 1'b1;
        tick();
        lit("pre_rst", 8'h01, 4'hF, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        lit("async_rst", 8'h00, 4'h0, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        lit("post_rst", 8'h01, 4'h0, 1'b0, 1'b0);

        // Plain scan and frame coherency.
        bus.en = 1'b0; bus.data_in = 32'h76543210; bus.blank_lz = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();
        lit("scan_d0", 8'h01, 4'h0, 1'b0, 1'b0);
        repeat (12) tick();
        lit("scan_d3", 8'h08, 4'h3, 1'b0, 1'b0);
        bus.data_in = 32'hFEDCBA98;
        repeat (16) tick();
        lit("scan_d7", 8'h80, 4'h7, 1'b0, 1'b0);
        repeat (3) tick();
        lit("wrap", 8'h80, 4'h7, 1'b0, 1'b1);
        tick();
        lit("new_d0", 8'h01, 4'h8, 1'b0, 1'b0);
        repeat (4) tick();
        lit("new_d1", 8'h02, 4'h9, 1'b0, 1'b0);

        // Leading-zero blanking.
        bus.en = 1'b0; bus.blank_lz = 1'b1; bus.data_in = 32'h00000A05;
        tick();
        bus.en = 1'b1;
        tick();
        lit("lz_d0", 8'h01, 4'h5, 1'b0, 1'b0);
        repeat (4) tick();
        lit("lz_d1", 8'h02, 4'h0, 1'b0, 1'b0);
        repeat (4) tick();
        lit("lz_d2", 8'h04, 4'hA, 1'b0, 1'b0);
        repeat (4) tick();
        lit("lz_d3", 8'h00, 4'h0, 1'b1, 1'b0);
        bus.data_in = 32'h0;
        repeat (20) tick();
        lit("zero_d0", 8'h01, 4'h0, 1'b0, 1'b0);
        repeat (4) tick();
        lit("zero_d1", 8'h00, 4'h0, 1'b1, 1'b0);

        // Enable drop during digit 5.
        bus.blank_lz = 1'b0;
        repeat (16) tick();
        lit("en_d5", 8'h20, 4'h0, 1'b0, 1'b0);
        bus.en = 1'b0; bus.data_in = 32'h12345678;
        tick();
        lit("en_off", 8'h00, 4'h0, 1'b0, 1'b0);
        bus.en = 1'b1;
        tick();
        lit("en_on", 8'h01, 4'h8, 1'b0, 1'b0);

        // Reset mid-frame at digit 6.
        repeat (24) tick();
        lit("mid_d6", 8'h40, 4'h2, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        lit("mid_rst", 8'h00, 4'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        lit("mid_restart", 8'h01, 4'h0, 1'b0, 1'b0);
        repeat (32) tick();
        lit("mid_reload", 8'h01, 4'h8, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
            else if (!bus.en && $urandom_range(0, 3) == 0) bus.en = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                w = '0;
                for (int d = 0; d < 8; d++)
                    if ($urandom_range(0, 1) == 1) w[4*d +: 4] = 4'($urandom_range(1, 15));
                w = w >> (4 * $urandom_range(0, 7));
                bus.data_in = w;
            end
            if ($urandom_range(0, 29) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
